mem_xfer_ctrl: RTL and testbench

- Sequencer for one CPU memory transaction. Drives the MAR load strobe, the four MDR enables and the memory read/write strobes.
- Accepts a read or write request from the control unit and handles variable memory wait states with a timeout.
- Returns done/err to the control unit. Sits between the control unit FSM and the MAR/MDR/memory datapath.

---
 rtl/mem_xfer_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_xfer_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_xfer_ctrl.sv
// Memory transaction sequencer. It steps the MAR/MDR/memory datapath
// through one read or write transaction. Memory wait states are bounded
// by a timeout, and the result is reported to the control unit as a
// done/err pulse.
module mem_xfer_ctrl #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic rd_req,
  input  logic wr_req,
  input  logic mem_ready,
  output logic busy,
  output logic done,
  output logic err,
  output logic mar_load,
  output logic mdr_in_bus_en,
  output logic mdr_in_mem_en,
  output logic mdr_out_bus_en,
  output logic mdr_out_mem_en,
  output logic mem_rd,
  output logic mem_wr
);

  typedef enum logic [2:0] {
    IDLE, MAR_LD, MDR_LD, RD_WAIT, WR_WAIT, RD_DONE, WR_DONE, ERR
  } state_t;

  // Moore outputs, registered so that they change only on clk edges.
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
    logic mar_load;
    logic mdr_in_bus_en;
    logic mdr_out_bus_en;
    logic mdr_out_mem_en;
    logic mem_rd;
    logic mem_wr;
  } outs_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic             op_wr_q, op_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  outs_t            outs_q, outs_d;

  // Next-state, transaction type and wait-state counter
  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A read wins over a simultaneous write. The write is dropped.
        if (rd_req) begin
          state_d = MAR_LD;
          op_wr_d = 1'b0;
        end else if (wr_req) begin
          state_d = MAR_LD;
          op_wr_d = 1'b1;
        end
      end
      MAR_LD: begin
        state_d = op_wr_q ? MDR_LD : RD_WAIT;
        cnt_d   = '0;
      end
      MDR_LD: begin
        state_d = WR_WAIT;
        cnt_d   = '0;
      end
      RD_WAIT, WR_WAIT: begin
        // If memory completes on the last allowed cycle, the success path wins.
        if (mem_ready)               state_d = (state_q == RD_WAIT) ? RD_DONE : WR_DONE;
        else if (cnt_q == WAIT_LAST) state_d = ERR;
        else                         cnt_d   = cnt_q + CNT_W'(1);
      end
      RD_DONE, WR_DONE, ERR: state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Decode the outputs from the state the FSM is entering, so the flops hold the Moore values
  always_comb begin
    outs_d      = '0;
    outs_d.busy = (state_d != IDLE);
    case (state_d)
      MAR_LD:  outs_d.mar_load      = 1'b1;
      MDR_LD:  outs_d.mdr_in_bus_en = 1'b1;
      RD_WAIT: outs_d.mem_rd        = 1'b1;
      WR_WAIT: begin
        outs_d.mem_wr         = 1'b1;
        outs_d.mdr_out_mem_en = 1'b1;
      end
      RD_DONE: begin
        outs_d.done           = 1'b1;
        outs_d.mdr_out_bus_en = 1'b1;
      end
      WR_DONE: outs_d.done = 1'b1;
      ERR: begin
        outs_d.done = 1'b1;
        outs_d.err  = 1'b1;
      end
      default: ;
    endcase
  end

  // State and output registers. Reset aborts any transaction without a done pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      cnt_q   <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      outs_q  <= outs_d;
    end
  end

  assign busy           = outs_q.busy;
  assign done           = outs_q.done;
  assign err            = outs_q.err;
  assign mar_load       = outs_q.mar_load;
  assign mdr_in_bus_en  = outs_q.mdr_in_bus_en;
  assign mdr_out_bus_en = outs_q.mdr_out_bus_en;
  assign mdr_out_mem_en = outs_q.mdr_out_mem_en;
  assign mem_rd         = outs_q.mem_rd;
  assign mem_wr         = outs_q.mem_wr;
  // The MDR captures memory data on the edge where the read completes.
  assign mdr_in_mem_en  = (state_q == RD_WAIT) & mem_ready;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl. Each transaction is described by its type and
// its number of wait states. The expected per-cycle output trace is built
// from that description, and the DUT outputs are compared against the
// trace on every falling edge.
module tb_mem_xfer_ctrl;
  localparam int TO = 15;

  // Output vector bit weights:
  // {busy,done,err,mar,mdr_in_bus,mdr_in_mem,mdr_out_bus,mdr_out_mem,rd,wr}
  localparam logic [9:0] V_BUSY = 10'b1000000000;
  localparam logic [9:0] V_DONE = 10'b0100000000;
  localparam logic [9:0] V_ERR  = 10'b0010000000;
  localparam logic [9:0] V_MAR  = 10'b0001000000;
  localparam logic [9:0] V_MIB  = 10'b0000100000;
  localparam logic [9:0] V_MIM  = 10'b0000010000;
  localparam logic [9:0] V_MOB  = 10'b0000001000;
  localparam logic [9:0] V_MOM  = 10'b0000000100;
  localparam logic [9:0] V_RD   = 10'b0000000010;
  localparam logic [9:0] V_WR   = 10'b0000000001;

  logic clk = 1'b0;
  logic reset, rd_req, wr_req, mem_ready;
  logic busy, done, err, mar_load, mdr_in_bus_en, mdr_in_mem_en;
  logic mdr_out_bus_en, mdr_out_mem_en, mem_rd, mem_wr;

  mem_xfer_ctrl #(.CNT_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req),
    .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
    .mar_load(mar_load), .mdr_in_bus_en(mdr_in_bus_en),
    .mdr_in_mem_en(mdr_in_mem_en), .mdr_out_bus_en(mdr_out_bus_en),
    .mdr_out_mem_en(mdr_out_mem_en), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_q[$];
  bit         rdy_q[$];
  logic [9:0] exp_vec = '0;
  bit         chk_en  = 1'b0;
  int         cur_idx = 0;
  int         done_idx, n_done, n_err, n_rd, n_wr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare process: outputs against the expected trace, the invariants,
  // and the per-transaction statistics.
  always @(negedge clk) begin
    if (chk_en) begin
      check("outputs", {busy, done, err, mar_load, mdr_in_bus_en, mdr_in_mem_en,
                        mdr_out_bus_en, mdr_out_mem_en, mem_rd, mem_wr}, exp_vec);
      check("inv_rd_wr", mem_rd & mem_wr, 0);
      check("inv_bus", ((32'(mar_load) + 32'(mdr_in_bus_en) + 32'(mdr_out_bus_en)) > 1), 0);
      if (done) begin
        n_done++;
        if (done_idx < 0) done_idx = cur_idx;
      end
      if (err)    n_err++;
      if (mem_rd) n_rd++;
      if (mem_wr) n_wr++;
    end
  end

  // Build the expected trace. Index 0 is the request cycle, in which the DUT
  // is still idle. A wait phase succeeds after waits+1 cycles when
  // waits < TO. Otherwise it times out after TO cycles.
  task automatic build(input bit is_wr, input int waits, input bit rdy_bg, input int abort_at);
    bit         ok;
    int         n;
    logic [9:0] wv, fin;
    exp_q.delete();
    rdy_q.delete();
    exp_q.push_back('0);            rdy_q.push_back(rdy_bg);
    exp_q.push_back(V_BUSY | V_MAR); rdy_q.push_back(rdy_bg);
    if (is_wr) begin
      exp_q.push_back(V_BUSY | V_MIB);
      rdy_q.push_back(rdy_bg);
    end
    ok = (waits < TO);
    n  = ok ? waits + 1 : TO;
    wv = is_wr ? (V_BUSY | V_WR | V_MOM) : (V_BUSY | V_RD);
    for (int k = 0; k < n; k++) begin
      bit last;
      last = ok && (k == n - 1);
      exp_q.push_back(wv | ((last && !is_wr) ? V_MIM : 10'b0));
      rdy_q.push_back(last);
    end
    fin = !ok ? (V_BUSY | V_DONE | V_ERR) : is_wr ? (V_BUSY | V_DONE) : (V_BUSY | V_DONE | V_MOB);
    exp_q.push_back(fin);
    rdy_q.push_back(rdy_bg);
    exp_q.push_back('0);
    rdy_q.push_back(1'b0);
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) begin
        void'(exp_q.pop_back());
        void'(rdy_q.pop_back());
      end
      exp_q.push_back('0); rdy_q.push_back(1'b0);
      exp_q.push_back('0); rdy_q.push_back(1'b0);
    end
  endtask

  // Drive one transaction cycle by cycle, following the built trace.
  task automatic run(input bit is_wr, input int waits, input bit rdy_bg, input bit both,
                     input int busy_wr_at, input int abort_at);
    build(is_wr, waits, rdy_bg, abort_at);
    done_idx = -1;
    n_done = 0;
    n_err = 0;
    n_rd = 0;
    n_wr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      cur_idx   = i;
      exp_vec   = exp_q[i];
      rd_req    = (i == 0) && (!is_wr || both);
      wr_req    = ((i == 0) && (is_wr || both)) || (i == busy_wr_at);
      mem_ready = rdy_q[i];
      reset     = !(i == abort_at);
      @(posedge clk);
      #1;
    end
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    mem_ready = 1'b0;
    reset     = 1'b1;
    exp_vec   = '0;
  endtask

  initial begin
    reset = 1'b0;
    rd_req = 1'b0;
    wr_req = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    wr_req = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait read, mem_ready high throughout
    run(0, 0, 1, 0, -1, -1);
    check("rd0_lat", done_idx, 3);
    check("rd0_err", n_err, 0);
    check("rd0_done", n_done, 1);

    // Write with 3 wait states
    run(1, 3, 0, 0, -1, -1);
    check("wr3_lat", done_idx, 7);
    check("wr3_wrcyc", n_wr, 4);

    // Read timeout
    run(0, 15, 0, 0, -1, -1);
    check("to_rdcyc", n_rd, 15);
    check("to_err", n_err, 1);
    check("to_lat", done_idx, 17);

    // mem_ready arrives on the timeout cycle, so the read succeeds
    run(0, 14, 0, 0, -1, -1);
    check("edge_err", n_err, 0);
    check("edge_rdcyc", n_rd, 15);
    check("edge_lat", done_idx, 17);

    // Simultaneous requests with a write pulse while busy
    run(0, 2, 0, 1, 2, -1);
    check("both_wr", n_wr, 0);
    check("both_done", n_done, 1);
    check("both_lat", done_idx, 5);

    // Reset during WR_WAIT (trace index 5), then a fresh read
    run(1, 10, 0, 0, -1, 5);
    check("abort_done", n_done, 0);
    run(0, 1, 0, 0, -1, -1);
    check("post_lat", done_idx, 4);

    // Zero-wait write
    run(1, 0, 0, 0, -1, -1);
    check("wr0_lat", done_idx, 4);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
